// File: rtl/score_bcd_feeder.sv
// Snake game score / high score keeper in packed BCD.
// Feeds hexs/points/LEs to the 4-digit seven-segment driver.
module score_bcd_feeder #(
  parameter int INC_STEP  = 1,
  parameter int BLINK_BIT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eat,
  input  logic        clr,
  input  logic        game_over,
  input  logic        show_high,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  LEs
);

  localparam logic [4:0] STEP5 = 5'(INC_STEP);
  localparam logic [BLINK_BIT:0] BONE =
    {{BLINK_BIT{1'b0}}, 1'b1};

  logic [15:0] score_q, score_d;
  logic [15:0] high_q, high_d;
  logic        go_q;
  logic [BLINK_BIT:0] blink_q, blink_d;
  logic [15:0] hexs_q, hexs_d;
  logic [3:0]  points_q, points_d;
  logic [3:0]  les_q, les_d;

  logic [15:0] sum;
  logic [4:0]  dsum;
  logic [4:0]  dadj;
  logic        cy;
  logic        go_rise;
  logic [15:0] sel;
  logic [3:0]  mask;

  assign go_rise = game_over & ~go_q;

  // BCD increment of score by INC_STEP; cy set means overflow past 9999
  always_comb begin
    sum  = 16'h0000;
    dsum = 5'd0;
    dadj = 5'd0;
    cy   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, score_q[4*i +: 4]}
           + ((i == 0) ? STEP5 : 5'd0)
           + {4'd0, cy};
      dadj = dsum - 5'd10;
      if (dsum > 5'd9) begin
        sum[4*i +: 4] = dadj[3:0];
        cy = 1'b1;
      end else begin
        sum[4*i +: 4] = dsum[3:0];
        cy = 1'b0;
      end
    end
  end

  // next score, high score and blink phase
  always_comb begin
    score_d = score_q;
    high_d  = high_q;
    blink_d = blink_q;
    if (clr) begin
      score_d = 16'h0000;
    end else if (eat && !game_over) begin
      score_d = cy ? 16'h9999 : sum;
    end
    if (go_rise && (score_q > high_q)) begin
      high_d = score_q;
    end
    if (go_rise) begin
      blink_d = '0;
    end else if (game_over) begin
      blink_d = blink_q + BONE;
    end else begin
      blink_d = '0;
    end
  end

  // display bundle from the current registers
  always_comb begin
    sel     = show_high ? high_q : score_q;
    mask    = 4'b0000;
    mask[3] = (sel[15:12] == 4'd0);
    mask[2] = mask[3] & (sel[11:8] == 4'd0);
    mask[1] = mask[2] & (sel[7:4] == 4'd0);
    hexs_d   = sel;
    points_d = show_high ? 4'b1000 : 4'b0000;
    les_d    = (game_over && blink_q[BLINK_BIT])
             ? 4'b1111 : mask;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q  <= 16'h0000;
      high_q   <= 16'h0000;
      go_q     <= 1'b0;
      blink_q  <= '0;
      hexs_q   <= 16'h0000;
      points_q <= 4'b0000;
      les_q    <= 4'b1110;
    end else begin
      score_q  <= score_d;
      high_q   <= high_d;
      go_q     <= game_over;
      blink_q  <= blink_d;
      hexs_q   <= hexs_d;
      points_q <= points_d;
      les_q    <= les_d;
    end
  end

  assign hexs   = hexs_q;
  assign points = points_q;
  assign LEs    = les_q;

endmodule

// File: tb/tb_score_bcd_feeder.sv
// Directed bench for score_bcd_feeder.
// Two instances: step 1 (main) and step 9 (carry/saturation).
module tb_score_bcd_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eat = 1'b0, clr = 1'b0;
  logic go = 1'b0, sh = 1'b0;
  logic eat9 = 1'b0, clr9 = 1'b0;
  logic go9 = 1'b0, sh9 = 1'b0;
  logic [15:0] hexs, hexs9;
  logic [3:0]  points, points9, les, les9;

  int n_chk = 0;
  int n_ok  = 0;

  always #5 clk = ~clk;

  score_bcd_feeder #(.INC_STEP(1), .BLINK_BIT(3)) u1 (
    .clk(clk), .rst(rst), .eat(eat), .clr(clr),
    .game_over(go), .show_high(sh),
    .hexs(hexs), .points(points), .LEs(les)
  );

  score_bcd_feeder #(.INC_STEP(9), .BLINK_BIT(3)) u9 (
    .clk(clk), .rst(rst), .eat(eat9), .clr(clr9),
    .game_over(go9), .show_high(sh9),
    .hexs(hexs9), .points(points9), .LEs(les9)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic eats(input int k);
    eat = 1'b1;
    step(k);
    eat = 1'b0;
    step(1);
  endtask

  task automatic eats9(input int k);
    eat9 = 1'b1;
    step(k);
    eat9 = 1'b0;
    step(1);
  endtask

  initial begin
    // 1 reset
    rst = 1'b1;
    step(3);
    chk("rst_hexs", hexs, 16'h0000);
    chk("rst_pts", {12'd0, points}, 16'h0);
    chk("rst_les", {12'd0, les}, 16'he);
    rst = 1'b0;
    step(10);
    chk("idle_hexs", hexs, 16'h0000);
    chk("idle_les", {12'd0, les}, 16'he);

    // 2 count to 12, then eat+clr
    eats(12);
    chk("s12_hexs", hexs, 16'h0012);
    chk("s12_les", {12'd0, les}, 16'hc);
    eat = 1'b1; clr = 1'b1;
    step(1);
    eat = 1'b0; clr = 1'b0;
    step(1);
    chk("clr_hexs", hexs, 16'h0000);
    chk("clr_les", {12'd0, les}, 16'he);

    // 3 step-9 carries and saturation
    eats9(111);
    chk("s999_hexs", hexs9, 16'h0999);
    chk("s999_les", {12'd0, les9}, 16'h8);
    eats9(1);
    chk("s1008_hexs", hexs9, 16'h1008);
    chk("s1008_les", {12'd0, les9}, 16'h0);
    eats9(999);
    chk("s9999_hexs", hexs9, 16'h9999);
    eats9(5);
    chk("sat_hexs", hexs9, 16'h9999);
    chk("sat_les", {12'd0, les9}, 16'h0);

    // 4 high 0030, then score 0042 and game over
    eats(30);
    go = 1'b1; step(1);
    go = 1'b0; step(1);
    clr = 1'b1; step(1);
    clr = 1'b0;
    eats(42);
    chk("s42_hexs", hexs, 16'h0042);
    go = 1'b1;
    step(1);
    sh = 1'b1;
    step(1);
    chk("hi42_hexs", hexs, 16'h0042);
    chk("hi42_pts", {12'd0, points}, 16'h8);
    chk("blink_off0", {12'd0, les}, 16'hc);
    step(8);
    chk("blink_on9", {12'd0, les}, 16'hf);
    step(7);
    chk("blink_on16", {12'd0, les}, 16'hf);
    step(1);
    chk("blink_off17", {12'd0, les}, 16'hc);
    eat = 1'b1; step(5);
    eat = 1'b0;
    sh = 1'b0;
    step(1);
    chk("go_eat_hexs", hexs, 16'h0042);
    chk("score_pts", {12'd0, points}, 16'h0);

    // 5 lower score keeps high
    go = 1'b0; step(1);
    clr = 1'b1; step(1);
    clr = 1'b0;
    eats(7);
    chk("s7_hexs", hexs, 16'h0007);
    go = 1'b1;
    step(1);
    sh = 1'b1;
    step(1);
    chk("hi_keep", hexs, 16'h0042);
    clr = 1'b1; step(1);
    clr = 1'b0; sh = 1'b0;
    step(1);
    chk("clr_score", hexs, 16'h0000);
    sh = 1'b1;
    step(1);
    chk("clr_high", hexs, 16'h0042);

    // 6 reset mid-blink
    step(6);
    chk("mid_blink", {12'd0, les}, 16'hf);
    rst = 1'b1; go = 1'b0; sh = 1'b0;
    step(1);
    chk("rst2_hexs", hexs, 16'h0000);
    chk("rst2_les", {12'd0, les}, 16'he);
    chk("rst2_pts", {12'd0, points}, 16'h0);
    rst = 1'b0; sh = 1'b1;
    step(1);
    chk("rst2_high", hexs, 16'h0000);
    chk("rst2_hpts", {12'd0, points}, 16'h8);
    chk("rst2_hles", {12'd0, les}, 16'he);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
